// File: rtl/line_peak_detect_if.sv
// rtl/line_peak_detect_if.sv - pixel stream in, per-line peak/saturation report out
interface line_peak_detect_if;
  logic        line_start;
  logic        pixel_valid;
  logic [7:0]  pixel_data;
  logic [7:0]  peak_out;
  logic [10:0] peak_pos;
  logic [10:0] sat_count;
  logic        update;
  logic        line_err;

  modport master (
    output line_start, pixel_valid, pixel_data,
    input  peak_out, peak_pos, sat_count, update, line_err
  );

  modport slave (
    input  line_start, pixel_valid, pixel_data,
    output peak_out, peak_pos, sat_count, update, line_err
  );
endinterface

// File: rtl/line_peak_detect.sv
// rtl/line_peak_detect.sv - per-line windowed peak value/position and saturation count
module line_peak_detect #(
  parameter int LINE_LEN  = 1024,
  parameter int WIN_START = 16,
  parameter int WIN_END   = 1007,
  parameter int SAT_LEVEL = 250
) (
  input  logic              clk_in,
  input  logic              reset_n,
  line_peak_detect_if.slave bus
);

  localparam logic [10:0] LAST_IDX = 11'(LINE_LEN - 1);
  localparam logic [10:0] WIN_LO   = 11'(WIN_START);
  localparam logic [10:0] WIN_HI   = 11'(WIN_END);
  localparam logic [7:0]  SAT_THR  = 8'(SAT_LEVEL);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  run_max, base_max, acc_max, peak_q;
  logic [10:0] run_pos, base_pos, acc_pos, pos_q;
  logic [10:0] run_sat, base_sat, acc_sat, sat_q;
  logic [10:0] pix_idx, cur_idx;
  logic        restart, accept, in_win, last_pix, err_q;

  // line_start restarts the line in any state, so a coincident pixel is index 0
  always_comb begin
    restart  = bus.line_start;
    base_max = restart ? 8'd0  : run_max;
    base_pos = restart ? 11'd0 : run_pos;
    base_sat = restart ? 11'd0 : run_sat;
    cur_idx  = restart ? 11'd0 : pix_idx;
    accept   = bus.pixel_valid && (restart || state == ACCUM);
    in_win   = (cur_idx >= WIN_LO) && (cur_idx <= WIN_HI);
    acc_max  = base_max;
    acc_pos  = base_pos;
    acc_sat  = base_sat;
    if (accept && in_win) begin
      if (bus.pixel_data > base_max) begin
        acc_max = bus.pixel_data;
        acc_pos = cur_idx;
      end
      if (bus.pixel_data >= SAT_THR) acc_sat = base_sat + 11'd1;
    end
    last_pix = accept && (cur_idx == LAST_IDX);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (restart) state_nxt = ACCUM;
      ACCUM:   state_nxt = ACCUM;
      REPORT:  state_nxt = restart ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (last_pix) state_nxt = REPORT;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state   <= IDLE;
      run_max <= '0;
      run_pos <= '0;
      run_sat <= '0;
      pix_idx <= '0;
      peak_q  <= '0;
      pos_q   <= '0;
      sat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= restart && (state == ACCUM);
      if (restart || accept) begin
        run_max <= acc_max;
        run_pos <= acc_pos;
        run_sat <= acc_sat;
        pix_idx <= accept ? cur_idx + 11'd1 : cur_idx;
      end
      if (last_pix) begin
        peak_q <= acc_max;
        pos_q  <= acc_pos;
        sat_q  <= acc_sat;
      end
    end
  end

  assign bus.peak_out  = peak_q;
  assign bus.peak_pos  = pos_q;
  assign bus.sat_count = sat_q;
  assign bus.update    = (state == REPORT);
  assign bus.line_err  = err_q;

endmodule
